// File: rtl/sub_pkg.sv
// Shared definitions for the multi-cycle 32-bit subtractor.
// Contents:
//   SUB_WIDTH, SUB_DIGIT  default operand width and bits per cycle
//   N_SLICES              slice count for the default configuration
//   IDLE / RUN / DONE     FSM state encoding
//   clog2()               index-width helper used to size the slice counter
package sub_pkg;

  localparam int unsigned SUB_WIDTH = 32;
  localparam int unsigned SUB_DIGIT = 8;
  localparam int unsigned N_SLICES  = SUB_WIDTH / SUB_DIGIT;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Ceiling log2, returning at least 1 so a single-slice counter still has a bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_subtractor_32_bit_borrow_slice.sv
// Combinational DIGIT-bit subtract slice: d = x - y - bi, with borrow-out bo.
// Ports:
//   x, y  in  DIGIT  minuend / subtrahend slice
//   bi    in  1      borrow-in
//   d     out DIGIT  difference slice
//   bo    out 1      borrow-out
module borrow_slice #(
  parameter int unsigned DIGIT = 8
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bi,
  output logic [DIGIT-1:0] d,
  output logic             bo
);

  logic [DIGIT:0] brw;

  assign brw[0] = bi;

  // Ripple of 1-bit full subtractors.
  for (genvar i = 0; i < DIGIT; i++) begin : g_fs
    assign d[i]     = x[i] ^ y[i] ^ brw[i];
    assign brw[i+1] = (~x[i] & y[i]) | (~x[i] & brw[i]) | (y[i] & brw[i]);
  end

  assign bo = brw[DIGIT];

endmodule

// File: rtl/seq_subtractor_32_bit.sv
// Multi-cycle subtractor: d = a - b - bin, DIGIT bits per clock, LSB slice first,
// behind a start/done handshake. One borrow_slice is reused every RUN cycle.
// Optional feature macro: SUB_FLAGS_EN adds registered zero/neg/ovf outputs.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           request, sampled only while ready=1
//   a, b, bin       operands, captured on the accepted start
//   ready           high in IDLE or DONE
//   done            one-cycle pulse when d/bout are valid
//   d, bout         difference and borrow-out, held until the next accepted start
//   zero, neg, ovf  result flags (SUB_FLAGS_EN only)
// DIGIT must divide WIDTH (legal: 1,2,4,8,16,32).
module seq_subtractor_32_bit
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             neg,
  output logic             ovf
`endif
);

  localparam int unsigned NSL   = WIDTH / DIGIT;
  localparam int unsigned IDX_W = clog2(NSL);

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             borrow;

  logic [DIGIT-1:0] x_s;
  logic [DIGIT-1:0] y_s;
  logic [DIGIT-1:0] d_s;
  logic             bo_s;
  logic [WIDTH-1:0] d_next;
  logic             last;

  assign x_s  = a_r[idx*DIGIT +: DIGIT];
  assign y_s  = b_r[idx*DIGIT +: DIGIT];
  assign last = (idx == IDX_W'(NSL - 1));

  borrow_slice #(
    .DIGIT(DIGIT)
  ) u_slice (
    .x (x_s),
    .y (y_s),
    .bi(borrow),
    .d (d_s),
    .bo(bo_s)
  );

  // Result with the current slice merged in; lets the flags see the complete
  // difference on the same edge that enters DONE.
  always_comb begin
    d_next = d;
    d_next[idx*DIGIT +: DIGIT] = d_s;
  end

  assign ready = (state == IDLE) || (state == DONE);
  assign done  = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      borrow <= 1'b0;
      d      <= '0;
      bout   <= 1'b0;
`ifdef SUB_FLAGS_EN
      zero   <= 1'b0;
      neg    <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state  <= RUN;
            a_r    <= a;
            b_r    <= b;
            borrow <= bin;
            idx    <= '0;
          end else begin
            state  <= IDLE;
          end
        end
        RUN: begin
          d      <= d_next;
          borrow <= bo_s;
          if (last) begin
            state <= DONE;
            idx   <= '0;
            bout  <= bo_s;
`ifdef SUB_FLAGS_EN
            zero  <= (d_next == '0);
            neg   <= d_next[WIDTH-1];
            ovf   <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (d_next[WIDTH-1] != a_r[WIDTH-1]);
`endif
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_subtractor_32_bit.sv
// Bench for seq_subtractor_32_bit: three instances (DIGIT = 1, 8, 32) share stimulus.
// A scoreboard captures the expected result of every accepted start from plain
// 33-bit arithmetic and checks d/bout/latency at each done pulse, plus d hold in IDLE.
// Directed vectors with literal expectations are checked on the DIGIT=8 instance.
module tb_seq_subtractor_32_bit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        bin = 1'b0;

  logic        ready_w[3];
  logic        done_w[3];
  logic [31:0] d_w[3];
  logic        bout_w[3];
`ifdef SUB_FLAGS_EN
  logic        zero_w[3];
  logic        neg_w[3];
  logic        ovf_w[3];
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_subtractor_32_bit #(.DIGIT(1)) u_d1 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .ready(ready_w[0]), .done(done_w[0]), .d(d_w[0]), .bout(bout_w[0])
`ifdef SUB_FLAGS_EN
    , .zero(zero_w[0]), .neg(neg_w[0]), .ovf(ovf_w[0])
`endif
  );

  seq_subtractor_32_bit #(.DIGIT(8)) u_d8 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .ready(ready_w[1]), .done(done_w[1]), .d(d_w[1]), .bout(bout_w[1])
`ifdef SUB_FLAGS_EN
    , .zero(zero_w[1]), .neg(neg_w[1]), .ovf(ovf_w[1])
`endif
  );

  seq_subtractor_32_bit #(.DIGIT(32)) u_d32 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .ready(ready_w[2]), .done(done_w[2]), .d(d_w[2]), .bout(bout_w[2])
`ifdef SUB_FLAGS_EN
    , .zero(zero_w[2]), .neg(neg_w[2]), .ovf(ovf_w[2])
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic int unsigned lat(input int i);
    return (i == 0) ? 32 : (i == 1) ? 4 : 1;
  endfunction

  // ---------------- scoreboard ----------------
  int unsigned cyc = 0;
  bit          pend[3];
  logic [31:0] exp_d[3];
  logic        exp_bo[3];
  logic        exp_z[3];
  logic        exp_n[3];
  logic        exp_o[3];
  int unsigned scyc[3];
  logic [31:0] last_d[3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      pend[i] = 1'b0;
      last_d[i] = '0;
    end
  end

  // Reset clears every expectation.
  initial forever begin
    @(posedge rst);
    for (int i = 0; i < 3; i++) begin
      pend[i] = 1'b0;
      last_d[i] = '0;
    end
  end

  // Capture the expected result of each accepted start.
  initial forever begin
    logic [32:0] r;
    @(posedge clk);
    cyc++;
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        if (ready_w[i] && start) begin
          if (pend[i]) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_overlap[%0d]: start accepted with result %h outstanding",
                     i, exp_d[i]);
          end
          r         = {1'b0, a} - {1'b0, b} - {32'b0, bin};
          exp_d[i]  = r[31:0];
          exp_bo[i] = r[32];
          exp_z[i]  = (r[31:0] == 32'd0);
          exp_n[i]  = r[31];
          exp_o[i]  = (a[31] != b[31]) && (r[31] != a[31]);
          scyc[i]   = cyc;
          pend[i]   = 1'b1;
        end
      end
    end
  end

  // Compare at every falling edge.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        if (done_w[i]) begin
          if (!pend[i]) begin
            vectors++;
            miscompares++;
            $display("FAIL spurious_done[%0d]: done=1, expected 0", i);
          end else begin
            chk($sformatf("sb_d[%0d]", i), d_w[i], exp_d[i]);
            chk($sformatf("sb_bout[%0d]", i), 32'(bout_w[i]), 32'(exp_bo[i]));
            chk($sformatf("sb_latency[%0d]", i), cyc - scyc[i], lat(i));
`ifdef SUB_FLAGS_EN
            chk($sformatf("sb_zero[%0d]", i), 32'(zero_w[i]), 32'(exp_z[i]));
            chk($sformatf("sb_neg[%0d]", i), 32'(neg_w[i]), 32'(exp_n[i]));
            chk($sformatf("sb_ovf[%0d]", i), 32'(ovf_w[i]), 32'(exp_o[i]));
`endif
            last_d[i] = exp_d[i];
            pend[i]   = 1'b0;
          end
        end else if (pend[i] && (cyc - scyc[i] > lat(i) + 1)) begin
          vectors++;
          miscompares++;
          $display("FAIL done_timeout[%0d]: no done after %0d cycles, expected %0d",
                   i, cyc - scyc[i], lat(i));
          pend[i] = 1'b0;
        end else if (ready_w[i] && !pend[i]) begin
          chk($sformatf("idle_hold_d[%0d]", i), d_w[i], last_d[i]);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (ready_w[0] && ready_w[1] && ready_w[2] && !done_w[0] && !done_w[1] && !done_w[2] &&
          !pend[0] && !pend[1] && !pend[2]) begin
        ok = 1'b1;
        break;
      end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL wait_idle: instances still busy after 80 cycles, expected idle");
    end
  endtask

  // Issue one operation; literal expectations checked on the DIGIT=8 instance.
  task automatic run_lit(input logic [31:0] ta, input logic [31:0] tb, input logic tbin,
                         input bit lit, input logic [31:0] ed, input logic ebo,
                         input logic ez, input logic en, input logic eo);
    bit seen;
    @(negedge clk);
    a = ta; b = tb; bin = tbin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (done_w[1]) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (lit) begin
      vectors++;
      if (!seen) begin
        miscompares++;
        $display("FAIL lit_done: done=0 after 20 cycles, expected 1");
      end else begin
        chk("lit_d", d_w[1], ed);
        chk("lit_bout", 32'(bout_w[1]), 32'(ebo));
`ifdef SUB_FLAGS_EN
        chk("lit_zero", 32'(zero_w[1]), 32'(ez));
        chk("lit_neg", 32'(neg_w[1]), 32'(en));
        chk("lit_ovf", 32'(ovf_w[1]), 32'(eo));
`endif
      end
    end
    wait_idle();
  endtask

  logic [31:0] got[4];
  int          nd;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100us, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_ready[%0d]", i), 32'(ready_w[i]), 32'd1);
      chk($sformatf("rst_done[%0d]", i), 32'(done_w[i]), 32'd0);
      chk($sformatf("rst_d[%0d]", i), d_w[i], 32'd0);
      chk($sformatf("rst_bout[%0d]", i), 32'(bout_w[i]), 32'd0);
    end
    #1 rst = 1'b0;

    // Basic and boundary vectors.
    run_lit(32'd5, 32'd3, 1'b0, 1'b1, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    run_lit(32'd0, 32'd1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    run_lit(32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    run_lit(32'h1234, 32'h1234, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    run_lit(32'd0, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    run_lit(32'h0001_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);

    // start held through RUN: one accept, then a back-to-back accept from DONE.
    nd = 0;
    @(negedge clk);
    a = 32'd10; b = 32'd4; bin = 1'b0; start = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      if (done_w[1] && nd < 4) begin
        got[nd] = d_w[1];
        nd++;
      end
      if (j < 5) a = a + 32'd100;
      if (j == 5) begin
        a = 32'd500;
        b = 32'd200;
      end
      if (j == 6) start = 1'b0;
    end
    chk("b2b_done_count", 32'(nd), 32'd2);
    if (nd >= 2) begin
      chk("b2b_first_d", got[0], 32'd6);
      chk("b2b_second_d", got[1], 32'd300);
    end
    wait_idle();

    // Reset in the 2nd RUN cycle of the DIGIT=8 instance.
    @(negedge clk);
    a = 32'd9; b = 32'd2; bin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("abort_ready[%0d]", i), 32'(ready_w[i]), 32'd1);
      chk($sformatf("abort_done[%0d]", i), 32'(done_w[i]), 32'd0);
      chk($sformatf("abort_d[%0d]", i), d_w[i], 32'd0);
    end
    @(negedge clk);
    #1 rst = 1'b0;
    run_lit(32'd7, 32'd7, 1'b0, 1'b1, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Random operands across all three DIGIT settings; checked by the scoreboard.
    for (int k = 0; k < 8; k++) begin
      run_lit($urandom, $urandom, 1'($urandom_range(1)), 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
